r4_sdf_commutator: RTL
======================

Name: r4_sdf_commutator

Overview:
- Frame-level commutator around the radix-4 butterfly of one SDF stage.
- Accepts a serial complex stream and buffers each N-sample frame. Issues 4-way parallel operand groups (x[k], x[k+L], x[k+2L], x[k+3L]) to the butterfly with a twiddle index.
- Captures the butterfly results after a fixed latency, then re-serializes them in bank order on a valid/ready output.

Parameters:
- WIDTH, 32, bit width of each real/imag sample component.
- N, 16, frame length; power of 4, >= 4.
- BF_LAT, 5, butterfly latency in clocks from operand presentation to result; >= 1.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_r, in_i  in  WIDTH each  serial input sample.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- ar, ai, br, bi, cr, ci, dr, di  out  WIDTH each  butterfly operands.
- tw_idx  out  log2(N/4) (min 1)  group index k, drives the external twiddle ROM.
- bf_issue  out  1  operands valid this cycle.
- r1r, r1i, r2r, r2i, r3r, r3i, r4r, r4i  in  WIDTH each  butterfly results.
- out_r, out_i  out  WIDTH each  serial result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- busy  out  1  state != FILL or fill count != 0.

Behaviour:
- L = N/4. A transfer occurs on in_valid&in_ready; output transfer on out_valid&out_ready.
- Reset (reset_n=0, asynchronous, any state):
  - state=FILL; all counters 0; valid delay line cleared.
  - Outputs in_ready=0 while asserted, then 1 in FILL. bf_issue=0, out_valid=0, operand/out data=0, tw_idx=0, busy=0.
  - Buffer contents are don't-care. A partially accepted frame is discarded; no partial output.
- Storage: input banks B0..B2 (L words each), output banks O0..O3 (L words each).
- FSM states: FILL, ISSUE, WAIT, UNLOAD.
- FILL:
  - in_ready=1. Sample with index j (0..3L-1) is written to B[j/L][j%L].
  - After the 3L-th transfer -> ISSUE.
- ISSUE:
  - in_ready=1. Transfer with index 3L+k registers operands the same edge: a=B0[k], b=B1[k], c=B2[k], d=input sample.
  - Operands are presented with bf_issue=1 and tw_idx=k the following cycle.
  - Gaps in in_valid insert bf_issue=0 cycles and hold the operands.
  - After the k=L-1 transfer -> WAIT.
- Result capture:
  - Issue valid and k are delayed BF_LAT cycles in a shift register.
  - When the delayed valid is set: O0[k]=r1, O1[k]=r2, O2[k]=r3, O3[k]=r4.
  - Capture continues irrespective of state.
- WAIT:
  - in_ready=0. Stay until the last group's result (k=L-1) is captured, then -> UNLOAD next cycle.
- UNLOAD:
  - in_ready=0. Emit O[q][k] for serial index q*L+k, 0..N-1, one per output transfer.
  - out_valid is registered. Data is held stable while out_valid&!out_ready.
  - After the N-th transfer: out_valid=0 next cycle, -> FILL.
- Arithmetic: none; pure data movement, no width change.
- Throughput: one frame per at least 2N+BF_LAT+2 cycles; no input/output overlap.
- Boundary cases:
  - in_valid while in_ready=0 is ignored and the sample is not consumed.
  - out_ready low for any number of cycles stalls UNLOAD without loss or duplication.
  - N=4 (L=1): FILL takes 3 transfers, ISSUE 1.

Decomposition:
- Shared package holds:
  - the FSM state encoding;
  - the function computing the index width log2 max(L,2);
  - the BF_LAT default matched to butterfly_radix4 pipeline depth.
- One sub-module is natural: r4_bank_ram, a single-write single-read L-deep complex register bank. It is instantiated 3x for input and 4x for output.

Test Plan:
- Reset mid-FILL after 5 samples (N=16) -> next 16 samples form a clean frame. Output matches the model; no stale data appears.
- N=16, in_valid constant, inputs x[j]=j+0i, stub butterfly (BF_LAT=5) returning r1=a, r2=b, r3=c, r4=d -> output sequence 0..15 in order; bf_issue pulses 4 times with tw_idx 0,1,2,3.
- Same stimulus with the real butterfly_radix4 and unity twiddles -> out[k] = a+b+c+d per group, e.g. group 0 = 24.
- in_valid toggling 1-0-1-0 during ISSUE -> bf_issue only on accepted cycles; results identical to the gapless case.
- out_ready low for 3 cycles at serial index 7 -> out_r held at O1[3] for 4 cycles; sequence continues at index 8; in_ready stays 0 throughout.
- in_valid high during WAIT/UNLOAD with distinct samples -> none consumed; first sample accepted after UNLOAD lands in B0[0].

Source files
------------

// File: rtl/r4_sdf_commutator_pkg.sv
// Shared types and helpers for the radix-4 SDF commutator.
package r4_sdf_commutator_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        UNLOAD = 2'd3
    } state_e;

    // Matches the pipeline depth of butterfly_radix4.
    localparam int unsigned BF_LAT_DEFAULT = 5;

    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned l;
        l = n / 4;
        if (l < 2) l = 2;
        return $clog2(l);
    endfunction

endpackage

// File: rtl/r4_bank_ram.sv
// Single-write, single-read complex register bank with combinational read.
module r4_bank_ram #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 2
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wr_i,
    input  logic [WIDTH-1:0] wi_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rr_o,
    output logic [WIDTH-1:0] ri_o
);

    logic [WIDTH-1:0] mem_r [2**AW];
    logic [WIDTH-1:0] mem_i [2**AW];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_r[waddr_i] <= wr_i;
            mem_i[waddr_i] <= wi_i;
        end
    end

    assign rr_o = mem_r[raddr_i];
    assign ri_o = mem_i[raddr_i];

endmodule

// File: rtl/r4_sdf_commutator.sv
// Frame commutator around a radix-4 butterfly: buffers a frame, issues
// 4-way operand groups, captures delayed results and re-serializes them.
module r4_sdf_commutator
    import r4_sdf_commutator_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned N      = 16,
    parameter int unsigned BF_LAT = BF_LAT_DEFAULT
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [WIDTH-1:0]          in_r,
    input  logic [WIDTH-1:0]          in_i,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          ar,
    output logic [WIDTH-1:0]          ai,
    output logic [WIDTH-1:0]          br,
    output logic [WIDTH-1:0]          bi,
    output logic [WIDTH-1:0]          cr,
    output logic [WIDTH-1:0]          ci,
    output logic [WIDTH-1:0]          dr,
    output logic [WIDTH-1:0]          di,
    output logic [idx_width(N)-1:0]   tw_idx,
    output logic                      bf_issue,
    input  logic [WIDTH-1:0]          r1r,
    input  logic [WIDTH-1:0]          r1i,
    input  logic [WIDTH-1:0]          r2r,
    input  logic [WIDTH-1:0]          r2i,
    input  logic [WIDTH-1:0]          r3r,
    input  logic [WIDTH-1:0]          r3i,
    input  logic [WIDTH-1:0]          r4r,
    input  logic [WIDTH-1:0]          r4i,
    output logic [WIDTH-1:0]          out_r,
    output logic [WIDTH-1:0]          out_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    localparam int unsigned L  = N / 4;
    localparam int unsigned AW = idx_width(N);
    typedef logic [AW-1:0] addr_t;
    localparam addr_t LAST = addr_t'(L - 1);

    state_e           state_q;
    addr_t            addr_q, tw_q, out_addr_q;
    logic [1:0]       bank_q, out_bank_q;
    logic             in_ready_q, issue_q, out_valid_q, all_loaded_q;
    logic [WIDTH-1:0] a_r_q, a_i_q, b_r_q, b_i_q, c_r_q, c_i_q, d_r_q, d_i_q;
    logic [WIDTH-1:0] out_r_q, out_i_q;
    logic [BF_LAT-1:0] vld_sr_q;
    addr_t            k_sr_q [BF_LAT];

    logic             xfer, cap_v;
    addr_t            cap_k;
    logic [WIDTH-1:0] b_rd_r [3];
    logic [WIDTH-1:0] b_rd_i [3];
    logic [WIDTH-1:0] o_rd_r [4];
    logic [WIDTH-1:0] o_rd_i [4];
    logic [WIDTH-1:0] cap_r [4];
    logic [WIDTH-1:0] cap_i [4];

    assign xfer  = in_valid & in_ready_q;
    assign cap_v = vld_sr_q[BF_LAT-1];
    assign cap_k = k_sr_q[BF_LAT-1];

    assign cap_r = '{r1r, r2r, r3r, r4r};
    assign cap_i = '{r1i, r2i, r3i, r4i};

    for (genvar g = 0; g < 3; g++) begin : g_in_bank
        r4_bank_ram #(.WIDTH(WIDTH), .AW(AW)) u_bank (
            .clk_i   (clock),
            .we_i    (xfer && state_q == FILL && bank_q == 2'(g)),
            .waddr_i (addr_q),
            .wr_i    (in_r),
            .wi_i    (in_i),
            .raddr_i (addr_q),
            .rr_o    (b_rd_r[g]),
            .ri_o    (b_rd_i[g])
        );
    end

    for (genvar g = 0; g < 4; g++) begin : g_out_bank
        r4_bank_ram #(.WIDTH(WIDTH), .AW(AW)) u_bank (
            .clk_i   (clock),
            .we_i    (cap_v),
            .waddr_i (cap_k),
            .wr_i    (cap_r[g]),
            .wi_i    (cap_i[g]),
            .raddr_i (out_addr_q),
            .rr_o    (o_rd_r[g]),
            .ri_o    (o_rd_i[g])
        );
    end

    // Capture runs independently of the FSM state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_sr_q <= '0;
            for (int unsigned i = 0; i < BF_LAT; i++) k_sr_q[i] <= '0;
        end else begin
            vld_sr_q[0] <= issue_q;
            k_sr_q[0]   <= tw_q;
            for (int unsigned i = 1; i < BF_LAT; i++) begin
                vld_sr_q[i] <= vld_sr_q[i-1];
                k_sr_q[i]   <= k_sr_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FILL;
            addr_q       <= '0;
            bank_q       <= '0;
            in_ready_q   <= 1'b0;
            issue_q      <= 1'b0;
            tw_q         <= '0;
            {a_r_q, a_i_q, b_r_q, b_i_q} <= '0;
            {c_r_q, c_i_q, d_r_q, d_i_q} <= '0;
            out_addr_q   <= '0;
            out_bank_q   <= '0;
            all_loaded_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_r_q      <= '0;
            out_i_q      <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    in_ready_q <= 1'b1;
                    if (xfer) begin
                        if (addr_q == LAST) begin
                            addr_q <= '0;
                            if (bank_q == 2'd2) begin
                                bank_q  <= '0;
                                state_q <= ISSUE;
                            end else begin
                                bank_q <= bank_q + 2'd1;
                            end
                        end else begin
                            addr_q <= addr_q + addr_t'(1);
                        end
                    end
                end
                ISSUE: begin
                    issue_q <= xfer;
                    if (xfer) begin
                        {a_r_q, a_i_q} <= {b_rd_r[0], b_rd_i[0]};
                        {b_r_q, b_i_q} <= {b_rd_r[1], b_rd_i[1]};
                        {c_r_q, c_i_q} <= {b_rd_r[2], b_rd_i[2]};
                        {d_r_q, d_i_q} <= {in_r, in_i};
                        tw_q <= addr_q;
                        if (addr_q == LAST) begin
                            addr_q     <= '0;
                            in_ready_q <= 1'b0;
                            state_q    <= WAIT;
                        end else begin
                            addr_q <= addr_q + addr_t'(1);
                        end
                    end
                end
                WAIT: begin
                    issue_q <= 1'b0;
                    if (cap_v && cap_k == LAST) state_q <= UNLOAD;
                end
                UNLOAD: begin
                    // One bubble on entry keeps the first read clear of the final capture write.
                    if (!out_valid_q || out_ready) begin
                        if (!all_loaded_q) begin
                            out_r_q     <= o_rd_r[out_bank_q];
                            out_i_q     <= o_rd_i[out_bank_q];
                            out_valid_q <= 1'b1;
                            if (out_addr_q == LAST) begin
                                out_addr_q <= '0;
                                if (out_bank_q == 2'd3) all_loaded_q <= 1'b1;
                                else                    out_bank_q   <= out_bank_q + 2'd1;
                            end else begin
                                out_addr_q <= out_addr_q + addr_t'(1);
                            end
                        end else begin
                            out_valid_q  <= 1'b0;
                            all_loaded_q <= 1'b0;
                            out_bank_q   <= '0;
                            in_ready_q   <= 1'b1;
                            state_q      <= FILL;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign bf_issue  = issue_q;
    assign tw_idx    = tw_q;
    assign {ar, ai, br, bi} = {a_r_q, a_i_q, b_r_q, b_i_q};
    assign {cr, ci, dr, di} = {c_r_q, c_i_q, d_r_q, d_i_q};
    assign out_r     = out_r_q;
    assign out_i     = out_i_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != FILL) || (addr_q != '0) || (bank_q != '0);

endmodule
